line_mem_server: RTL and testbench

LINE_MEM_SERVER -- requirements
Module: line_mem_server

---
 rtl/line_mem_server_pkg.sv | 20 ++
 rtl/line_mem_server_rr_arbiter2.sv | 40 ++++
 rtl/line_mem_server.sv | 173 +++++++++++++++++
 tb/tb_line_mem_server.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/line_mem_server_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : line_mem_server_pkg
//  Purpose  : Definitions shared by the line memory server and the caches that
//             talk to it: line geometry and the server FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package line_mem_server_pkg;

  localparam int LINE_BITS        = 128;
  localparam int LINE_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/line_mem_server_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter2
//  Purpose  : Two-requester round-robin arbiter. When both requests are high
//             the port that was not granted last wins; a lone request always
//             wins. The last-grant pointer moves only when advance is high.
//  Ports    : clk, rst_n    - clock, asynchronous active-low reset
//             req[1:0]      - request per port
//             advance       - the current grant is being consumed
//             grant[1:0]    - one-hot grant (combinational)
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // 1 = port 1 was granted last. Resets to 1 so port 0 wins the first tie.
  logic r_last;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = r_last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (advance && (|grant)) begin
      r_last <= grant[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/line_mem_server.sv
`default_nettype none
// ============================================================================
//  Module   : line_mem_server
//  Purpose  : Two-port 128-bit line memory with a fixed access latency. One
//             transaction is in flight at a time; ports are arbitrated
//             round-robin. Ready pulses one cycle, LATENCY cycles after the
//             accepting edge; writes commit at the edge that ends the pulse.
//  Ports    : clk, rst_n                 - clock, asynchronous active-low reset
//             pN_req / pN_we             - request (held until ready) / write
//             pN_addr                    - byte address, bits [3:0] ignored
//             pN_wdata / pN_rdata        - write line / returned line
//             pN_ready                   - single-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module line_mem_server
  import line_mem_server_pkg::*;
#(
  parameter int MEM_LINES = 1024,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [31:0]          p0_addr,
  input  logic [LINE_BITS-1:0] p0_wdata,
  output logic [LINE_BITS-1:0] p0_rdata,
  output logic                 p0_ready,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [31:0]          p1_addr,
  input  logic [LINE_BITS-1:0] p1_wdata,
  output logic [LINE_BITS-1:0] p1_rdata,
  output logic                 p1_ready
);

  localparam int         c_IDX_W    = $clog2(MEM_LINES);
  localparam logic [7:0] c_CNT_LOAD = 8'(LATENCY - 1);

  logic [LINE_BITS-1:0] mem [MEM_LINES];

  state_t               r_state;
  state_t               w_next_state;
  logic [7:0]           r_cnt;
  logic                 r_port;
  logic                 r_we;
  logic [c_IDX_W-1:0]   r_idx;
  logic [LINE_BITS-1:0] r_wdata;
  logic [LINE_BITS-1:0] r_p0_rdata;
  logic [LINE_BITS-1:0] r_p1_rdata;

  logic [1:0]           w_grant;
  logic                 w_accept;
  logic                 w_gnt_port;
  logic                 w_gnt_we;
  logic [c_IDX_W-1:0]   w_gnt_idx;
  logic [LINE_BITS-1:0] w_gnt_wdata;

  logic                 w_load_rdata;
  logic                 w_resp_port;
  logic                 w_resp_we;
  logic [c_IDX_W-1:0]   w_resp_idx;
  logic [LINE_BITS-1:0] w_resp_wdata;
  logic [LINE_BITS-1:0] w_resp_line;

  // Offset bits and address bits above the line index are don't-care.
  logic w_unused;
  assign w_unused = ^{p0_addr[31:LINE_OFFSET_BITS+c_IDX_W], p0_addr[LINE_OFFSET_BITS-1:0],
                      p1_addr[31:LINE_OFFSET_BITS+c_IDX_W], p1_addr[LINE_OFFSET_BITS-1:0]};

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({p1_req, p0_req}),
    .advance (w_accept),
    .grant   (w_grant)
  );

  assign w_accept    = (r_state == IDLE) && (|w_grant);
  assign w_gnt_port  = w_grant[1];
  assign w_gnt_we    = w_gnt_port ? p1_we : p0_we;
  assign w_gnt_idx   = w_gnt_port ? p1_addr[LINE_OFFSET_BITS +: c_IDX_W]
                                  : p0_addr[LINE_OFFSET_BITS +: c_IDX_W];
  assign w_gnt_wdata = w_gnt_port ? p1_wdata : p0_wdata;

  // Next state and ready outputs.
  always_comb begin
    w_next_state = r_state;
    p0_ready     = 1'b0;
    p1_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next_state = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        // Leave when this decrement brings the counter to zero.
        if (r_cnt <= 8'd1) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        w_next_state = IDLE;
        p0_ready     = !r_port;
        p1_ready     = r_port;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The response line is registered on the edge entering RESP. With
  // LATENCY=1 that edge is also the accepting edge, so the transaction
  // fields come straight from the granted port instead of the latches.
  always_comb begin
    w_load_rdata = (w_next_state == RESP) && (r_state != RESP);
    w_resp_port  = r_port;
    w_resp_we    = r_we;
    w_resp_idx   = r_idx;
    w_resp_wdata = r_wdata;
    if (r_state == IDLE) begin
      w_resp_port  = w_gnt_port;
      w_resp_we    = w_gnt_we;
      w_resp_idx   = w_gnt_idx;
      w_resp_wdata = w_gnt_wdata;
    end
    w_resp_line = w_resp_we ? w_resp_wdata : mem[w_resp_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_port     <= 1'b0;
      r_we       <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_port  <= w_gnt_port;
        r_we    <= w_gnt_we;
        r_idx   <= w_gnt_idx;
        r_wdata <= w_gnt_wdata;
        r_cnt   <= c_CNT_LOAD;
      end else if ((r_state == BUSY) && (r_cnt != 8'd0)) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_load_rdata) begin
        if (w_resp_port) begin
          r_p1_rdata <= w_resp_line;
        end else begin
          r_p0_rdata <= w_resp_line;
        end
      end
    end
  end

  // Storage is not reset. Reset drops the FSM out of RESP asynchronously,
  // so an aborted write never reaches the array.
  always_ff @(posedge clk) begin
    if ((r_state == RESP) && r_we) begin
      mem[r_idx] <= r_wdata;
    end
  end

  assign p0_rdata = r_p0_rdata;
  assign p1_rdata = r_p1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_line_mem_server.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_mem_server
//  Purpose  : Directed self-checking bench. Instance a runs LATENCY=4, instance
//             b runs LATENCY=1; both use MEM_LINES=1024.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_line_mem_server;

  localparam logic [127:0] c_D4 = 128'h4444_0004_4444_0004_4444_0004_4444_0004;
  localparam logic [127:0] c_A5 = {16{8'hA5}};
  localparam logic [127:0] c_WR = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] c_EX = 128'hE000_0000_0000_0000_0000_0000_0000_0E0E;
  localparam logic [127:0] c_Y  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] c_Z  = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] c_B  = 128'h0B0B_0B0B_0000_FFFF_0B0B_0B0B_0000_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n_a, rst_n_b;
  logic         a_p0_req, a_p0_we, a_p1_req, a_p1_we, a_p0_ready, a_p1_ready;
  logic [31:0]  a_p0_addr, a_p1_addr;
  logic [127:0] a_p0_wdata, a_p1_wdata, a_p0_rdata, a_p1_rdata;
  logic         b_p0_req, b_p0_we, b_p1_req, b_p1_we, b_p0_ready, b_p1_ready;
  logic [31:0]  b_p0_addr, b_p1_addr;
  logic [127:0] b_p0_wdata, b_p1_wdata, b_p0_rdata, b_p1_rdata;

  int n_checks = 0;
  int n_errors = 0;

  line_mem_server #(.MEM_LINES(1024), .LATENCY(4)) dut_a (
    .clk(clk), .rst_n(rst_n_a),
    .p0_req(a_p0_req), .p0_we(a_p0_we), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
    .p0_rdata(a_p0_rdata), .p0_ready(a_p0_ready),
    .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
    .p1_rdata(a_p1_rdata), .p1_ready(a_p1_ready)
  );

  line_mem_server #(.MEM_LINES(1024), .LATENCY(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b),
    .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
    .p0_rdata(b_p0_rdata), .p0_ready(b_p0_ready),
    .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
    .p1_rdata(b_p1_rdata), .p1_ready(b_p1_ready)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on instance a. lat is the number of edges from the
  // accepting edge (1) to the edge after which ready is visible; -1 on timeout.
  task automatic txn_a(input bit port, input bit we, input logic [31:0] addr,
                       input logic [127:0] wd, input bit early_drop,
                       output logic [127:0] rd, output int lat);
    logic seen_other;
    logic still_high;
    seen_other = 1'b0;
    lat = -1;
    rd  = '0;
    @(negedge clk);
    if (port) begin
      a_p1_req = 1'b1; a_p1_we = we; a_p1_addr = addr; a_p1_wdata = wd;
    end else begin
      a_p0_req = 1'b1; a_p0_we = we; a_p0_addr = addr; a_p0_wdata = wd;
    end
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (early_drop && n == 1) begin
        a_p0_req = 1'b0; a_p1_req = 1'b0;
      end
      if (port ? a_p1_ready : a_p0_ready) begin
        lat = n;
        rd  = port ? a_p1_rdata : a_p0_rdata;
        a_p0_req = 1'b0; a_p1_req = 1'b0;
      end
      if (port ? a_p0_ready : a_p1_ready) seen_other = 1'b1;
    end
    @(posedge clk); #1;
    still_high = port ? a_p1_ready : a_p0_ready;
    check_val("ready_single_cycle", {127'd0, still_high}, 128'd0);
    check_val("other_ready_quiet", {127'd0, seen_other}, 128'd0);
  endtask

  logic [127:0] rd;
  int           lat;
  int           pulse_n [4];
  logic         pulse_p [4];
  int           np, bad, both;

  initial begin
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    a_p0_req = 0; a_p0_we = 0; a_p0_addr = '0; a_p0_wdata = '0;
    a_p1_req = 0; a_p1_we = 0; a_p1_addr = '0; a_p1_wdata = '0;
    b_p0_req = 0; b_p0_we = 0; b_p0_addr = '0; b_p0_wdata = '0;
    b_p1_req = 0; b_p1_we = 0; b_p1_addr = '0; b_p1_wdata = '0;
    repeat (3) @(negedge clk);
    check_val("reset_p0_ready", {127'd0, a_p0_ready}, 128'd0);
    check_val("reset_p1_ready", {127'd0, a_p1_ready}, 128'd0);
    check_val("reset_p0_rdata", a_p0_rdata, 128'd0);
    check_val("reset_p1_rdata", a_p1_rdata, 128'd0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;

    // Preload line 4 through port 1, then the single-read case.
    txn_a(1'b1, 1'b1, 32'h0000_0040, c_D4, 1'b0, rd, lat);
    check_val("preload_lat", 128'(lat), 128'd4);
    txn_a(1'b0, 1'b0, 32'h0000_0040, '0, 1'b0, rd, lat);
    check_val("read40_lat", 128'(lat), 128'd4);
    check_val("read40_data", rd, c_D4);

    // Write then read at 0x100.
    txn_a(1'b1, 1'b1, 32'h0000_0100, c_A5, 1'b0, rd, lat);
    check_val("wr100_rdata_echo", rd, c_A5);
    txn_a(1'b0, 1'b0, 32'h0000_0100, '0, 1'b0, rd, lat);
    check_val("rd100_data", rd, c_A5);
    repeat (3) @(posedge clk);
    #1;
    check_val("p0_rdata_hold", a_p0_rdata, c_A5);
    check_val("p1_rdata_hold", a_p1_rdata, c_A5);

    // Index wraps modulo MEM_LINES; offset bits are ignored.
    txn_a(1'b0, 1'b1, 32'h0000_4010, c_WR, 1'b0, rd, lat);
    txn_a(1'b1, 1'b0, 32'h0000_0010, '0, 1'b0, rd, lat);
    check_val("wrap_read", rd, c_WR);
    txn_a(1'b1, 1'b0, 32'h0000_001F, '0, 1'b0, rd, lat);
    check_val("offset_ignored", rd, c_WR);

    // Request dropped right after acceptance still completes and commits.
    txn_a(1'b0, 1'b1, 32'h0000_0200, c_EX, 1'b1, rd, lat);
    check_val("early_drop_lat", 128'(lat), 128'd4);
    txn_a(1'b1, 1'b0, 32'h0000_0200, '0, 1'b0, rd, lat);
    check_val("early_drop_commit", rd, c_EX);

    // Reset during BUSY of a write aborts it.
    txn_a(1'b0, 1'b1, 32'h0000_0300, c_Y, 1'b0, rd, lat);
    @(negedge clk);
    a_p0_req = 1'b1; a_p0_we = 1'b1; a_p0_addr = 32'h0000_0300; a_p0_wdata = c_Z;
    @(posedge clk); #1;
    a_p0_req = 1'b0;
    @(posedge clk); #1;
    rst_n_a = 1'b0;
    np = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (n == 3) rst_n_a = 1'b1;
      if (a_p0_ready || a_p1_ready) np++;
    end
    check_val("abort_no_ready", 128'(np), 128'd0);
    check_val("abort_rdata_reset", a_p0_rdata, 128'd0);

    // Contention straight after reset: p0, p1, p0, p1, spaced LATENCY+1.
    @(negedge clk);
    a_p0_req = 1'b1; a_p0_we = 1'b0; a_p0_addr = 32'h0000_0040;
    a_p1_req = 1'b1; a_p1_we = 1'b0; a_p1_addr = 32'h0000_0100;
    np = 0; bad = 0; both = 0;
    for (int n = 1; n <= 40 && np < 4; n++) begin
      @(posedge clk); #1;
      if (a_p0_ready && a_p1_ready) both++;
      if (a_p0_ready || a_p1_ready) begin
        pulse_n[np] = n;
        pulse_p[np] = a_p1_ready;
        if (a_p1_ready ? (a_p1_rdata !== c_A5) : (a_p0_rdata !== c_D4)) bad++;
        np++;
      end
    end
    a_p0_req = 1'b0; a_p1_req = 1'b0;
    check_val("cont_pulses", 128'(np), 128'd4);
    check_val("cont_both_ready", 128'(both), 128'd0);
    check_val("cont_data", 128'(bad), 128'd0);
    check_val("cont_order0", {127'd0, pulse_p[0]}, 128'd0);
    check_val("cont_order1", {127'd0, pulse_p[1]}, 128'd1);
    check_val("cont_order2", {127'd0, pulse_p[2]}, 128'd0);
    check_val("cont_order3", {127'd0, pulse_p[3]}, 128'd1);
    check_val("cont_t0", 128'(pulse_n[0]), 128'd4);
    check_val("cont_t1", 128'(pulse_n[1]), 128'd9);
    check_val("cont_t3", 128'(pulse_n[3]), 128'd19);

    repeat (2) @(posedge clk);
    txn_a(1'b0, 1'b0, 32'h0000_0300, '0, 1'b0, rd, lat);
    check_val("abort_line_kept", rd, c_Y);

    // LATENCY=1 instance: preload then back-to-back reads.
    @(negedge clk);
    b_p0_req = 1'b1; b_p0_we = 1'b1; b_p0_addr = 32'h0000_0020; b_p0_wdata = c_B;
    lat = -1;
    for (int n = 1; n <= 10 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (b_p0_ready) begin
        lat = n;
        b_p0_req = 1'b0;
      end
    end
    check_val("l1_write_lat", 128'(lat), 128'd1);
    @(negedge clk);
    @(negedge clk);
    b_p0_req = 1'b1; b_p0_we = 1'b0;
    np = 0; bad = 0; both = 0;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (b_p0_ready) begin
        np++;
        if ((n % 2) == 0) bad++;
        if (b_p0_rdata !== c_B) bad++;
      end
      if (b_p1_ready) both++;
    end
    b_p0_req = 1'b0;
    check_val("l1_pulse_count", 128'(np), 128'd5);
    check_val("l1_pulse_spacing", 128'(bad), 128'd0);
    check_val("l1_p1_quiet", 128'(both), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
